// File: rtl/par_to_serial.sv
// Parallel-to-serial converter with a one-word holding buffer, so a new word
// can be queued while the current one streams out and back-to-back words leave no gap.
module par_to_serial #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_en,
   output logic             data_out,
   output logic             out_valid,
   output logic             frame_start
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state,       w_state;
   logic [WIDTH-1:0] r_shift,       w_shift;
   logic [CW-1:0]    r_count,       w_count;
   logic [WIDTH-1:0] r_hold,        w_hold;
   logic             r_hold_valid,  w_hold_valid;
   logic             r_data_out,    w_data_out;
   logic             r_out_valid,   w_out_valid;
   logic             r_frame_start, w_frame_start;

   logic             w_accept;
   logic             w_consume;
   logic             w_free;
   logic [WIDTH-1:0] w_load_word;

   // Bit presented first from a word, and the word with that bit removed.
   function automatic logic first_bit(input logic [WIDTH-1:0] word);
      return LSB_FIRST ? word[0] : word[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] word);
      return LSB_FIRST ? (word >> 1) : (word << 1);
   endfunction

   assign in_ready    = ~r_hold_valid & ~reset;
   assign w_accept    = in_valid & in_ready;
   assign w_consume   = r_out_valid & out_en;
   assign w_free      = (r_state == ST_IDLE) | (w_consume & (r_count == LAST));
   assign w_load_word = r_hold_valid ? r_hold : data_in;

   // NOTE: every variable gets its default before any branch so no latch is inferred.
   always_comb begin
      w_state       = r_state;
      w_shift       = r_shift;
      w_count       = r_count;
      w_hold        = r_hold;
      w_hold_valid  = r_hold_valid;
      w_data_out    = r_data_out;
      w_out_valid   = r_out_valid;
      w_frame_start = r_frame_start;

      if (w_consume) begin
         w_count       = r_count + CW'(1);
         w_data_out    = first_bit(r_shift);
         w_shift       = drop_bit(r_shift);
         w_frame_start = 1'b0;
      end

      if (w_free) begin
         if (r_hold_valid || w_accept) begin
            w_state       = ST_SHIFT;
            w_out_valid   = 1'b1;
            w_frame_start = 1'b1;
            w_count       = '0;
            w_data_out    = first_bit(w_load_word);
            w_shift       = drop_bit(w_load_word);
            w_hold_valid  = 1'b0;
         end else begin
            w_state       = ST_IDLE;
            w_out_valid   = 1'b0;
            w_frame_start = 1'b0;
            w_count       = '0;
            w_data_out    = 1'b0;
            w_shift       = '0;
         end
      end else if (w_accept) begin
         w_hold       = data_in;
         w_hold_valid = 1'b1;
      end
   end

   // NOTE: state is registered with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_shift       <= '0;
         r_count       <= '0;
         r_hold_valid  <= 1'b0;
         r_data_out    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_shift       <= w_shift;
         r_count       <= w_count;
         r_hold_valid  <= w_hold_valid;
         r_data_out    <= w_data_out;
         r_out_valid   <= w_out_valid;
         r_frame_start <= w_frame_start;
      end
   end

   // NOTE: the holding word is qualified by r_hold_valid, so its data needs no reset.
   always_ff @(posedge clk) begin
      r_hold <= w_hold;
   end

   assign data_out    = r_data_out;
   assign out_valid   = r_out_valid;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_par_to_serial.sv
// Bench for par_to_serial: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a word-queue reference model, plus directed scenarios.
module tb_par_to_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] data_in;
   logic         in_valid;
   logic         out_en;

   logic in_ready_l, data_out_l, out_valid_l, frame_start_l;
   logic in_ready_m, data_out_m, out_valid_m, frame_start_m;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: words owned by the block (shifter first, then holding buffer)
   // and the index of the bit currently on the line for the oldest word.
   logic [W-1:0] m_q[$];
   int           m_pos = 0;

   // Bits actually consumed downstream (out_valid & out_en), per instance.
   logic obs_l[$];
   logic obs_m[$];

   par_to_serial #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
      .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready_l), .out_en(out_en), .data_out(data_out_l),
      .out_valid(out_valid_l), .frame_start(frame_start_l)
   );

   par_to_serial #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
      .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready_m), .out_en(out_en), .data_out(data_out_m),
      .out_valid(out_valid_m), .frame_start(frame_start_m)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] pack(input logic q[$]);
      logic [15:0] p = '0;
      foreach (q[i]) p = {p[14:0], q[i]};
      return p;
   endfunction

   // One clock cycle: drive inputs, check in_ready, advance model, check registered outputs.
   task automatic step(input logic v, input logic [W-1:0] d, input logic en, input logic rst);
      logic         acc, exp_rdy, exp_v, exp_l, exp_m, exp_fs;
      logic [W-1:0] word;
      in_valid = v;
      data_in  = d;
      out_en   = en;
      reset    = rst;
      #1;
      exp_rdy = !rst && (m_q.size() < 2);
      n_checks++;
      if (in_ready_l !== exp_rdy || in_ready_m !== exp_rdy) begin
         n_errors++;
         $display("FAIL in_ready: got %b/%b expected %b", in_ready_l, in_ready_m, exp_rdy);
      end
      if (out_valid_l && en) begin
         obs_l.push_back(data_out_l);
         obs_m.push_back(data_out_m);
      end
      acc = v && exp_rdy;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_pos = 0;
      end else begin
         if (m_q.size() > 0 && en) begin
            m_pos++;
            if (m_pos == W) begin
               void'(m_q.pop_front());
               m_pos = 0;
            end
         end
         if (acc) m_q.push_back(d);
      end
      @(negedge clk);
      exp_v  = (m_q.size() > 0);
      word   = exp_v ? m_q[0] : '0;
      exp_l  = exp_v ? word[m_pos] : 1'b0;
      exp_m  = exp_v ? word[W-1-m_pos] : 1'b0;
      exp_fs = exp_v && (m_pos == 0);
      n_checks++;
      if (out_valid_l !== exp_v || out_valid_m !== exp_v) begin
         n_errors++;
         $display("FAIL out_valid: got %b/%b expected %b", out_valid_l, out_valid_m, exp_v);
      end
      n_checks++;
      if (data_out_l !== exp_l || data_out_m !== exp_m) begin
         n_errors++;
         $display("FAIL data_out: got %b/%b expected %b/%b", data_out_l, data_out_m, exp_l, exp_m);
      end
      n_checks++;
      if (frame_start_l !== exp_fs || frame_start_m !== exp_fs) begin
         n_errors++;
         $display("FAIL frame_start: got %b/%b expected %b", frame_start_l, frame_start_m, exp_fs);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b1, 8'h5A, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      n_checks++;
      if (data_out_l !== 1'b0 || out_valid_l !== 1'b0 || frame_start_l !== 1'b0 || in_ready_l !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_state: got d=%b v=%b fs=%b rdy=%b expected 0 0 0 1",
                  data_out_l, out_valid_l, frame_start_l, in_ready_l);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      obs_l.delete(); obs_m.delete();
      step(1'b1, 8'hB2, 1'b1, 1'b0);
      n_checks++;
      if (frame_start_l !== 1'b1 || out_valid_l !== 1'b1) begin
         n_errors++;
         $display("FAIL single_latency: got fs=%b v=%b expected 1 1", frame_start_l, out_valid_l);
      end
      idle(8);
      n_checks++;
      if (out_valid_l !== 1'b0) begin
         n_errors++;
         $display("FAIL single_end: out_valid got %b expected 0", out_valid_l);
      end
      n_checks++;
      if (obs_l.size() != 8 || pack(obs_l) !== 16'b0000_0000_0100_1101) begin
         n_errors++;
         $display("FAIL single_lsb_bits: got %0d bits %b expected 01001101", obs_l.size(), pack(obs_l));
      end
      n_checks++;
      if (obs_m.size() != 8 || pack(obs_m) !== 16'b0000_0000_1011_0010) begin
         n_errors++;
         $display("FAIL single_msb_bits: got %0d bits %b expected 10110010", obs_m.size(), pack(obs_m));
      end
   endtask

   task automatic test_back_to_back();
      obs_l.delete(); obs_m.delete();
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      n_checks++;
      if (in_ready_l !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_hold_ready: in_ready got %b expected 0", in_ready_l);
      end
      idle(15);
      n_checks++;
      if (obs_l.size() != 16 || pack(obs_l) !== 16'b1010_0101_0011_1100) begin
         n_errors++;
         $display("FAIL b2b_bits: got %0d bits %b expected 1010010100111100", obs_l.size(), pack(obs_l));
      end
      n_checks++;
      if (out_valid_l !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_end: out_valid got %b expected 0", out_valid_l);
      end
   endtask

   task automatic test_stall();
      obs_l.delete(); obs_m.delete();
      step(1'b1, 8'hB2, 1'b1, 1'b0);
      idle(3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         n_checks++;
         if (data_out_l !== 1'b0 || out_valid_l !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_hold: got d=%b v=%b expected 0 1", data_out_l, out_valid_l);
         end
      end
      idle(4);
      n_checks++;
      if (out_valid_l !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_cycle11: out_valid got %b expected 1", out_valid_l);
      end
      idle(1);
      n_checks++;
      if (out_valid_l !== 1'b0 || pack(obs_l) !== 16'b0000_0000_0100_1101 || obs_l.size() != 8) begin
         n_errors++;
         $display("FAIL stall_bits: got v=%b %0d bits %b expected 0 and 01001101",
                  out_valid_l, obs_l.size(), pack(obs_l));
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      idle(4);
      step(1'b1, 8'h55, 1'b1, 1'b1);
      n_checks++;
      if (out_valid_l !== 1'b0 || data_out_l !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid: got v=%b d=%b expected 0 0", out_valid_l, data_out_l);
      end
      obs_l.delete(); obs_m.delete();
      step(1'b1, 8'h01, 1'b1, 1'b0);
      n_checks++;
      if (frame_start_l !== 1'b1 || data_out_l !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_mid_first: got fs=%b d=%b expected 1 1", frame_start_l, data_out_l);
      end
      idle(9);
      n_checks++;
      if (obs_l.size() != 8 || pack(obs_l) !== 16'b0000_0000_1000_0000) begin
         n_errors++;
         $display("FAIL reset_mid_bits: got %0d bits %b expected 10000000", obs_l.size(), pack(obs_l));
      end
   endtask

   task automatic test_hold_full();
      obs_l.delete(); obs_m.delete();
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h77, 1'b0, 1'b0);
         n_checks++;
         if (in_ready_l !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_full_ready: in_ready got %b expected 0", in_ready_l);
         end
      end
      idle(17);
      n_checks++;
      if (obs_l.size() != 16 || pack(obs_l) !== 16'b1000_1000_0100_0100) begin
         n_errors++;
         $display("FAIL hold_full_bits: got %0d bits %b expected 1000100001000100", obs_l.size(), pack(obs_l));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 59) == 0));
      end
      idle(20);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      data_in  = '0;
      out_en   = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_hold_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
